// File: rtl/binary2double_pkg.sv
// Shared definitions for the fixed-point <-> binary64 converter pair.
//   - type codes carried alongside a fixed-point value
//   - IEEE-754 binary64 constants used when packing special values
//   - state encoding of the fixed-to-double sequencer
package binary2double_pkg;

  // Type codes; 5..7 are unassigned and are treated as NaN by consumers.
  localparam logic [2:0] TYPE_NORMAL = 3'd0;
  localparam logic [2:0] TYPE_NAN    = 3'd1;
  localparam logic [2:0] TYPE_PINF   = 3'd2;
  localparam logic [2:0] TYPE_NINF   = 3'd3;
  localparam logic [2:0] TYPE_RANGE  = 3'd4;

  localparam int          EXP_BIAS = 1023;
  localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF     = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF     = 64'hFFF0_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_NORM   = 2'd1,
    ST_PACK   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/binary2double_pack.sv
// Combinational packer: builds the binary64 word from the normalised
// magnitude and the captured type code.
// Ports:
//   sign_i   captured sign (1 = negative)
//   type_i   captured 3-bit type code
//   frac_i   normalised magnitude below its leading one (W-1 bits)
//   k_i      number of left shifts applied during normalisation
//   zero_i   magnitude was zero
//   double_o packed IEEE-754 binary64 word
module binary2double_pack
  import binary2double_pkg::*;
#(
  parameter int INT_W  = 14,
  parameter int FRAC_W = 4,
  parameter int W      = INT_W + FRAC_W,
  parameter int KW     = (W > 1) ? $clog2(W) : 1
) (
  input  logic          sign_i,
  input  logic [2:0]    type_i,
  input  logic [W-2:0]  frac_i,
  input  logic [KW-1:0] k_i,
  input  logic          zero_i,
  output logic [63:0]   double_o
);

  logic [10:0] exp_w;
  logic [51:0] man_w;

  always_comb begin
    // The leading one of the magnitude sits at weight 2^(INT_W-1) after
    // normalisation, minus one per shift applied.
    exp_w = 11'(EXP_BIAS + INT_W - 1 - int'(k_i));
    // Hidden bit dropped; remaining bits are left-aligned in the mantissa.
    // W <= 53 guarantees the value is exact, so no rounding is needed.
    man_w = '0;
    man_w[51 -: (W-1)] = frac_i;

    double_o = QNAN;
    case (type_i)
      TYPE_NORMAL: double_o = zero_i ? 64'h0 : {sign_i, exp_w, man_w};
      TYPE_NAN:    double_o = QNAN;
      TYPE_PINF:   double_o = PINF;
      TYPE_NINF:   double_o = NINF;
      TYPE_RANGE:  double_o = {sign_i, 11'h7FF, 52'h0};
      default:     double_o = QNAN;
    endcase
  end

endmodule

// File: rtl/binary2double.sv
// Sign-magnitude fixed-point to IEEE-754 binary64 converter.
// Normalisation shifts the magnitude left one bit per cycle until its MSB
// is set, then the packer builds the word.
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   i_ready       conversion request (level, held until result taken)
//   sign          sign of the value (1 = negative)
//   integer_part  unsigned integer magnitude, INT_W bits
//   fraction_part unsigned fraction magnitude, FRAC_W bits
//   i_type        type code (see package)
//   o_double      binary64 result, held until the next conversion packs
//   o_valid       result valid, high in OUTPUT
//   o_busy        high whenever the sequencer is not idle
//   o_state       current sequencer state, for observation
//
// Handshake: the request is sampled as a level. A high i_ready in IDLE
// captures the inputs; the result is presented with o_valid until i_ready
// is seen low, at which edge o_valid falls and the block returns to IDLE.
// A request that drops early still runs to completion and shows o_valid for
// a single cycle.
module binary2double
  import binary2double_pkg::*;
#(
  parameter int INT_W  = 14,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ready,
  input  logic              sign,
  input  logic [INT_W-1:0]  integer_part,
  input  logic [FRAC_W-1:0] fraction_part,
  input  logic [2:0]        i_type,
  output logic [63:0]       o_double,
  output logic              o_valid,
  output logic              o_busy,
  output logic [1:0]        o_state
);

  localparam int W  = INT_W + FRAC_W;
  localparam int KW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [KW-1:0] k_q, k_d;
  logic          sign_q, sign_d;
  logic [2:0]    type_q, type_d;
  logic [63:0]   dbl_q, dbl_d;

  logic          zero_w;
  logic [63:0]   packed_w;

  assign zero_w = (sh_q == '0);

  binary2double_pack #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W),
    .W      (W),
    .KW     (KW)
  ) u_pack (
    .sign_i   (sign_q),
    .type_i   (type_q),
    .frac_i   (sh_q[W-2:0]),
    .k_i      (k_q),
    .zero_i   (zero_w),
    .double_o (packed_w)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    k_d     = k_q;
    sign_d  = sign_q;
    type_d  = type_q;
    dbl_d   = dbl_q;

    case (state_q)
      ST_IDLE: begin
        if (i_ready) begin
          sh_d    = {integer_part, fraction_part};
          k_d     = '0;
          sign_d  = sign;
          type_d  = i_type;
          state_d = (i_type != TYPE_NORMAL) ? ST_PACK : ST_NORM;
        end
      end
      ST_NORM: begin
        // Zero never normalises; it is packed as +0 directly.
        if (zero_w || sh_q[W-1]) begin
          state_d = ST_PACK;
        end else begin
          sh_d = sh_q << 1;
          k_d  = k_q + 1'b1;
        end
      end
      ST_PACK: begin
        dbl_d   = packed_w;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (!i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      k_q     <= '0;
      sign_q  <= 1'b0;
      type_q  <= 3'd0;
      dbl_q   <= 64'h0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
      sign_q  <= sign_d;
      type_q  <= type_d;
      dbl_q   <= dbl_d;
    end
  end

  assign o_double = dbl_q;
  assign o_valid  = (state_q == ST_OUTPUT);
  assign o_busy   = (state_q != ST_IDLE);
  assign o_state  = state_q;

endmodule

// File: tb/tb_binary2double.sv
module tb_binary2double;

  localparam int INT_W  = 14;
  localparam int FRAC_W = 4;
  localparam int W      = INT_W + FRAC_W;
  localparam int MAX_WAIT = 40;

  logic              clk;
  logic              rst;
  logic              i_ready;
  logic              sign;
  logic [INT_W-1:0]  integer_part;
  logic [FRAC_W-1:0] fraction_part;
  logic [2:0]        i_type;
  logic [63:0]       o_double;
  logic              o_valid;
  logic              o_busy;
  logic [1:0]        o_state;

  int checks;
  int failures;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  binary2double #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_ready       (i_ready),
    .sign          (sign),
    .integer_part  (integer_part),
    .fraction_part (fraction_part),
    .i_type        (i_type),
    .o_double      (o_double),
    .o_valid       (o_valid),
    .o_busy        (o_busy),
    .o_state       (o_state)
  );

  // scoreboard
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: value = (-1)^sign * mag / 2^FRAC_W as a real number,
  // converted to its binary64 bit pattern.
  function automatic logic [63:0] model_double(input logic s, input logic [W-1:0] mag,
                                               input logic [2:0] ty);
    real v;
    case (ty)
      3'd0: begin
        if (mag == 0) return 64'h0;
        v = real'(mag) / (2.0 ** FRAC_W);
        if (s) v = -v;
        return $realtobits(v);
      end
      3'd2: return 64'h7FF0_0000_0000_0000;
      3'd3: return 64'hFFF0_0000_0000_0000;
      3'd4: return s ? 64'hFFF0_0000_0000_0000 : 64'h7FF0_0000_0000_0000;
      default: return 64'h7FF8_0000_0000_0000;
    endcase
  endfunction

  // Edges after the capture edge until o_valid; -1 marks a special type,
  // whose result must appear no later than the second edge.
  function automatic int model_latency(input logic [W-1:0] mag, input logic [2:0] ty);
    int msb;
    if (ty != 3'd0) return -1;
    if (mag == 0) return 2;
    msb = 0;
    for (int i = 0; i < W; i++) if (mag[i]) msb = i;
    return 2 + (W - 1 - msb);
  endfunction

  // driver: one full conversion with handshake and checks
  task automatic run_conv(input string tag, input logic s, input logic [INT_W-1:0] ip,
                          input logic [FRAC_W-1:0] fp, input logic [2:0] ty,
                          input logic [63:0] exp_d, input int exp_lat, input int hold);
    int lat;
    logic [63:0] want;
    exp_q.push_back(exp_d);
    sign = s; integer_part = ip; fraction_part = fp; i_type = ty;
    i_ready = 1'b1;
    step();  // capture edge
    // inputs ignored after capture
    sign = ~s; integer_part = ~ip; fraction_part = ~fp; i_type = 3'd0;
    lat = 0;
    while (!o_valid && lat < MAX_WAIT) begin
      step();
      lat++;
    end
    want = exp_q.pop_front();
    if (exp_lat >= 0) chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    else              chk({tag, "_latency_le2"}, 64'((lat >= 1) && (lat <= 2)), 64'd1);
    chk({tag, "_double"}, o_double, want);
    chk({tag, "_busy"}, 64'(o_busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      step();
      chk({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
      chk({tag, "_hold_double"}, o_double, want);
    end
    i_ready = 1'b0;
    step();
    chk({tag, "_drop_valid"}, 64'(o_valid), 64'd0);
    chk({tag, "_drop_state"}, 64'(o_state), 64'd0);
    chk({tag, "_keep_double"}, o_double, want);
  endtask

  typedef struct {
    string       name;
    logic        s;
    logic [13:0] ip;
    logic [3:0]  fp;
    logic [2:0]  ty;
    logic [63:0] exp_d;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [W-1:0] mag;
    logic [2:0]   ty;
    logic         s;
    int           nb;
    int           lat;

    checks = 0;
    failures = 0;

    vecs[0]  = '{"one",      1'b0, 14'd1,     4'd0,  3'd0, 64'h3FF0_0000_0000_0000, 15};
    vecs[1]  = '{"max",      1'b0, 14'd16383, 4'd15, 3'd0, 64'h40CF_FFF8_0000_0000, 2};
    vecs[2]  = '{"min_neg",  1'b1, 14'd0,     4'd1,  3'd0, 64'hBFB0_0000_0000_0000, 19};
    vecs[3]  = '{"neg_zero", 1'b1, 14'd0,     4'd0,  3'd0, 64'h0,                   2};
    vecs[4]  = '{"ninf",     1'b0, 14'd5,     4'd0,  3'd3, 64'hFFF0_0000_0000_0000, -1};
    vecs[5]  = '{"range_n",  1'b1, 14'd5,     4'd0,  3'd4, 64'hFFF0_0000_0000_0000, -1};
    vecs[6]  = '{"range_p",  1'b0, 14'd5,     4'd0,  3'd4, 64'h7FF0_0000_0000_0000, -1};
    vecs[7]  = '{"type6",    1'b1, 14'd7,     4'd3,  3'd6, 64'h7FF8_0000_0000_0000, -1};
    vecs[8]  = '{"nan",      1'b1, 14'd0,     4'd0,  3'd1, 64'h7FF8_0000_0000_0000, -1};
    vecs[9]  = '{"pinf",     1'b1, 14'd0,     4'd0,  3'd2, 64'h7FF0_0000_0000_0000, -1};
    vecs[10] = '{"neg_two",  1'b1, 14'd2,     4'd0,  3'd0, 64'hC000_0000_0000_0000, 14};
    vecs[11] = '{"half",     1'b0, 14'd0,     4'd8,  3'd0, 64'h3FE0_0000_0000_0000, 16};

    rst = 1'b0; i_ready = 1'b0; sign = 1'b0;
    integer_part = '0; fraction_part = '0; i_type = 3'd0;
    repeat (2) step();
    chk("reset_valid", 64'(o_valid), 64'd0);
    chk("reset_busy", 64'(o_busy), 64'd0);
    chk("reset_double", o_double, 64'h0);
    chk("reset_state", 64'(o_state), 64'd0);
    rst = 1'b1;
    step();
    chk("idle_busy", 64'(o_busy), 64'd0);

    // table-driven vectors
    for (int i = 0; i < 12; i++)
      run_conv(vecs[i].name, vecs[i].s, vecs[i].ip, vecs[i].fp, vecs[i].ty,
               vecs[i].exp_d, vecs[i].exp_lat, 0);

    // 3.25 with a long hold of the request
    run_conv("hold_3p25", 1'b0, 14'd3, 4'b0100, 3'd0, 64'h400A_0000_0000_0000, 14, 5);

    // asynchronous reset in the middle of normalisation
    sign = 1'b0; integer_part = 14'd1; fraction_part = 4'd0; i_type = 3'd0;
    i_ready = 1'b1;
    step();
    repeat (3) step();
    chk("pre_reset_busy", 64'(o_busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(o_valid), 64'd0);
    chk("async_rst_busy", 64'(o_busy), 64'd0);
    chk("async_rst_double", o_double, 64'h0);
    chk("async_rst_state", 64'(o_state), 64'd0);
    step();
    rst = 1'b1;
    run_conv("after_reset", 1'b0, 14'd1, 4'd0, 3'd0, 64'h3FF0_0000_0000_0000, 15, 0);

    // one-cycle request pulse: runs to completion, valid for one cycle
    sign = 1'b0; integer_part = 14'd1; fraction_part = 4'd0; i_type = 3'd0;
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    lat = 0;
    while (!o_valid && lat < MAX_WAIT) begin
      step();
      lat++;
    end
    chk("pulse_latency", 64'(lat), 64'd15);
    chk("pulse_double", o_double, 64'h3FF0_0000_0000_0000);
    step();
    chk("pulse_valid_one_cycle", 64'(o_valid), 64'd0);
    chk("pulse_idle", 64'(o_state), 64'd0);
    repeat (4) step();
    chk("pulse_no_restart", 64'(o_busy), 64'd0);

    // randomized conversions against the reference model
    for (int r = 0; r < 40; r++) begin
      nb  = $urandom_range(W, 0);
      mag = (nb == 0) ? '0 : W'($urandom_range(32'((64'd1 << nb) - 1), 0));
      s   = 1'($urandom_range(1, 0));
      ty  = ($urandom_range(9, 0) < 7) ? 3'd0 : 3'($urandom_range(7, 1));
      run_conv("rand", s, mag[W-1:FRAC_W], mag[FRAC_W-1:0], ty,
               model_double(s, mag, ty), model_latency(mag, ty),
               $urandom_range(2, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
